// File: rtl/isr_pipe_param.sv
// Integer square root by shift/subtract digit recurrence, STEPS root bits per clock.
// Floor or round-to-nearest result with saturation; the remainder reported is always the floor remainder.
module isr_pipe_param #(
  parameter int WIDTH = 64,
  parameter int STEPS = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   value,
  input  logic               round_mode,
  input  logic               abort,
  output logic               ready,
  output logic [WIDTH/2-1:0] result,
  output logic [WIDTH/2:0]   remainder,
  output logic               sat,
  output logic               done
);

  localparam int HW = WIDTH / 2;
  localparam int RW = HW + 2;
  localparam int N  = HW / STEPS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [WIDTH-1:0] op_r, op_s;
  logic             mode_r;
  logic [HW-1:0]    root_r, root_s;
  logic [RW-1:0]    rem_r, rem_s;
  logic [CW-1:0]    cnt_r;
  logic             ready_r, done_r, sat_r;
  logic [HW-1:0]    result_r;
  logic [HW:0]      remainder_r;
  logic [HW-1:0]    fin_result_s;
  logic             fin_sat_s;

  // Next-state logic; abort wins over start and over normal progress.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (abort) begin
          state_s = IDLE;
        end else if (start) begin
          state_s = CALC;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (abort) begin
          state_s = IDLE;
        end else if (cnt_r == {CW{1'b0}}) begin
          state_s = FINISH;
        end else begin
          state_s = CALC;
        end
      end
      FINISH:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // STEPS recurrence steps per clock, consuming operand bit pairs MSB first.
  always_comb begin
    logic [RW-1:0] trial_v;
    rem_s   = rem_r;
    root_s  = root_r;
    op_s    = op_r;
    trial_v = {RW{1'b0}};
    for (int i = 0; i < STEPS; i++) begin
      rem_s   = {rem_s[RW-3:0], op_s[WIDTH-1:WIDTH-2]};
      trial_v = {root_s, 2'b01};
      if (rem_s >= trial_v) begin
        rem_s  = rem_s - trial_v;
        root_s = {root_s[HW-2:0], 1'b1};
      end else begin
        root_s = {root_s[HW-2:0], 1'b0};
      end
      op_s = {op_s[WIDTH-3:0], 2'b00};
    end
  end

  // Round up when the floor remainder exceeds the root; an all-ones root cannot be incremented.
  always_comb begin
    fin_result_s = root_r;
    fin_sat_s    = 1'b0;
    if (mode_r && (rem_r > {2'b00, root_r})) begin
      if (&root_r) begin
        fin_result_s = {HW{1'b1}};
        fin_sat_s    = 1'b1;
      end else begin
        fin_result_s = root_r + {{(HW-1){1'b0}}, 1'b1};
        fin_sat_s    = 1'b0;
      end
    end else begin
      fin_result_s = root_r;
      fin_sat_s    = 1'b0;
    end
  end

  // State register, datapath and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      op_r        <= {WIDTH{1'b0}};
      mode_r      <= 1'b0;
      root_r      <= {HW{1'b0}};
      rem_r       <= {RW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      ready_r     <= 1'b1;
      done_r      <= 1'b0;
      sat_r       <= 1'b0;
      result_r    <= {HW{1'b0}};
      remainder_r <= {(HW+1){1'b0}};
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == IDLE);
      done_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!abort && start) begin
            op_r   <= value;
            mode_r <= round_mode;
            root_r <= {HW{1'b0}};
            rem_r  <= {RW{1'b0}};
            cnt_r  <= CW'(N - 1);
          end
        end
        CALC: begin
          if (!abort) begin
            op_r   <= op_s;
            root_r <= root_s;
            rem_r  <= rem_s;
            if (cnt_r != {CW{1'b0}}) begin
              cnt_r <= cnt_r - CW'(1);
            end
          end
        end
        FINISH: begin
          if (!abort) begin
            result_r    <= fin_result_s;
            remainder_r <= rem_r[HW:0];
            sat_r       <= fin_sat_s;
            done_r      <= 1'b1;
          end
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign ready     = ready_r;
  assign done      = done_r;
  assign sat       = sat_r;
  assign result    = result_r;
  assign remainder = remainder_r;

endmodule

// File: tb/tb_isr_pipe_param.sv
// Directed bench for isr_pipe_param: one STEPS=1 and one STEPS=2 instance, 64-bit operands.
module tb_isr_pipe_param;

  logic        clock;
  logic        reset;
  logic        start1, mode1, abort1, ready1, sat1, done1;
  logic [63:0] value1;
  logic [31:0] result1;
  logic [32:0] remainder1;
  logic        start2, mode2, abort2, ready2, sat2, done2;
  logic [63:0] value2;
  logic [31:0] result2;
  logic [32:0] remainder2;

  int checks   = 0;
  int failures = 0;
  int lat;
  bit rdy_bad;
  int extra;

  isr_pipe_param #(.WIDTH(64), .STEPS(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .value(value1),
    .round_mode(mode1), .abort(abort1), .ready(ready1), .result(result1),
    .remainder(remainder1), .sat(sat1), .done(done1)
  );

  isr_pipe_param #(.WIDTH(64), .STEPS(2)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .value(value2),
    .round_mode(mode2), .abort(abort2), .ready(ready2), .result(result2),
    .remainder(remainder2), .sat(sat2), .done(done2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one operation on dut1, scramble its inputs after accept, measure edges to done.
  task automatic op1(input logic [63:0] v, input logic m, output int l, output bit rb);
    @(negedge clock);
    value1 = v; mode1 = m; start1 = 1'b1;
    @(posedge clock); #1;
    start1 = 1'b0; value1 = 64'hA5A5_5A5A_DEAD_BEEF; mode1 = ~m;
    l = 0; rb = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clock); #1;
      if (done1) begin
        l = k;
        break;
      end
      if (ready1) rb = 1'b1;
    end
  endtask

  task automatic op2(input logic [63:0] v, input logic m, output int l);
    @(negedge clock);
    value2 = v; mode2 = m; start2 = 1'b1;
    @(posedge clock); #1;
    start2 = 1'b0;
    l = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clock); #1;
      if (done2) begin
        l = k;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    start1 = 1'b0; mode1 = 1'b0; abort1 = 1'b0; value1 = 64'd0;
    start2 = 1'b0; mode2 = 1'b0; abort2 = 1'b0; value2 = 64'd0;
    #22;
    chk("rst_ready", ready1, 1);
    chk("rst_done", done1, 0);
    chk("rst_result", result1, 0);
    chk("rst_rem", remainder1, 0);
    chk("rst_sat", sat1, 0);
    @(negedge clock);
    reset = 1'b1;

    // Floor of 1000
    op1(64'd1000, 1'b0, lat, rdy_bad);
    chk("t1_latency", lat, 33);
    chk("t1_ready_low", rdy_bad, 0);
    chk("t1_result", result1, 31);
    chk("t1_rem", remainder1, 39);
    chk("t1_sat", sat1, 0);

    // Round-to-nearest cases
    op1(64'd1000, 1'b1, lat, rdy_bad);
    chk("t2a_result", result1, 32);
    chk("t2a_rem", remainder1, 39);
    op1(64'd99, 1'b1, lat, rdy_bad);
    chk("t2b_result", result1, 10);
    chk("t2b_rem", remainder1, 18);
    op1(64'd1000000, 1'b1, lat, rdy_bad);
    chk("t2c_result", result1, 1000);
    chk("t2c_rem", remainder1, 0);

    // Saturation at the top of the range
    op1(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, lat, rdy_bad);
    chk("t3a_result", result1, 32'hFFFF_FFFF);
    chk("t3a_rem", remainder1, 33'h1_FFFF_FFFE);
    chk("t3a_sat", sat1, 1);
    op1(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, lat, rdy_bad);
    chk("t3b_result", result1, 32'hFFFF_FFFF);
    chk("t3b_sat", sat1, 0);

    // Back-to-back start in the done cycle; stray start during CALC
    chk("t4_ready_in_done", ready1, 1);
    value1 = 64'd0; mode1 = 1'b0; start1 = 1'b1;
    @(posedge clock); #1;
    start1 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clock); #1;
      if (k == 10) start1 = 1'b1;
      if (k == 11) start1 = 1'b0;
      if (done1) begin
        lat = k;
        break;
      end
    end
    chk("t4_latency", lat, 33);
    chk("t4_result", result1, 0);
    chk("t4_rem", remainder1, 0);
    chk("t4_sat", sat1, 0);
    extra = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (done1) extra++;
    end
    chk("t4_no_extra_done", extra, 0);

    // STEPS=2 instance, then abort mid-operation
    op2(64'd144, 1'b0, lat);
    chk("t5_latency", lat, 17);
    chk("t5_result", result2, 12);
    chk("t5_rem", remainder2, 0);
    @(negedge clock);
    value2 = 64'd1000; start2 = 1'b1;
    @(posedge clock); #1;
    start2 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock); #1;
    end
    abort2 = 1'b1;
    @(posedge clock); #1;
    abort2 = 1'b0;
    chk("t5_abort_ready", ready2, 1);
    extra = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clock); #1;
      if (done2) extra++;
    end
    chk("t5_abort_no_done", extra, 0);
    chk("t5_abort_result", result2, 12);

    // Asynchronous reset mid-CALC, then a fresh operation
    op1(64'd1000, 1'b0, lat, rdy_bad);
    chk("t6_pre_result", result1, 31);
    @(negedge clock);
    value1 = 64'd1000000; start1 = 1'b1;
    @(posedge clock); #1;
    start1 = 1'b0;
    repeat (6) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk("t6_rst_result", result1, 0);
    chk("t6_rst_rem", remainder1, 0);
    chk("t6_rst_ready", ready1, 1);
    chk("t6_rst_done", done1, 0);
    chk("t6_rst_result2", result2, 0);
    @(negedge clock);
    reset = 1'b1;
    extra = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (done1) extra++;
    end
    chk("t6_no_done_after_reset", extra, 0);
    op1(64'd50, 1'b0, lat, rdy_bad);
    chk("t6_latency", lat, 33);
    chk("t6_result", result1, 7);
    chk("t6_rem", remainder1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
